// File: rtl/rca_slice_sequencer_if.sv
// rca_slice_sequencer_if: start/done request bus between a controller and the slice sequencer.
// RCA_SEQ_OVERFLOW_EN adds the signed-overflow flag ovf.
interface rca_slice_sequencer_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef RCA_SEQ_OVERFLOW_EN
   logic             ovf;
`endif
   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout
`ifdef RCA_SEQ_OVERFLOW_EN
      , input ovf
`endif
   );
   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout
`ifdef RCA_SEQ_OVERFLOW_EN
      , output ovf
`endif
   );
endinterface

// File: rtl/rca_slice_sequencer.sv
// rca_slice_sequencer: WIDTH-bit a+b+cin computed over WIDTH/SLICE cycles on one SLICE-bit ripple slice.
// RCA_SEQ_OVERFLOW_EN adds the registered signed-overflow output ovf.
module rca_slice_sequencer #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input logic                  clk,
   input logic                  rst,
   rca_slice_sequencer_if.slave bus
);
   localparam int NSLICE = WIDTH / SLICE;
   localparam int IW = NSLICE > 1 ? $clog2(NSLICE) : 1;
   if (SLICE < 1 || WIDTH % SLICE != 0) begin : g_bad_cfg
      $error("WIDTH must be a positive multiple of SLICE");
   end
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t           state;
   logic [WIDTH-1:0] a, b, wk, wk_n;
   logic             c;
   logic [IW-1:0]    idx;
   logic [SLICE-1:0] sa, sb;
   logic [SLICE:0]   s;
   logic             last;
   always_comb begin
      sa = a[idx*SLICE +: SLICE];
      sb = b[idx*SLICE +: SLICE];
      s = {1'b0, sa} + {1'b0, sb} + {{SLICE{1'b0}}, c};
      wk_n = wk;
      wk_n[idx*SLICE +: SLICE] = s[SLICE-1:0];
   end
   assign last = idx == IW'(NSLICE - 1);
`ifdef RCA_SEQ_OVERFLOW_EN
   // carry into the slice MSB recovered from its sum bit and operand bits
   logic msb_cin;
   assign msb_cin = s[SLICE-1] ^ sa[SLICE-1] ^ sb[SLICE-1];
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         a        <= '0;
         b        <= '0;
         wk       <= '0;
         c        <= 1'b0;
         idx      <= '0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
         bus.sum  <= '0;
         bus.cout <= 1'b0;
`ifdef RCA_SEQ_OVERFLOW_EN
         bus.ovf  <= 1'b0;
`endif
      end else begin
         case (state)
            RUN: begin
               wk  <= wk_n;
               c   <= s[SLICE];
               idx <= last ? '0 : idx + 1'b1;
               if (last) begin
                  state    <= DONE;
                  bus.busy <= 1'b0;
                  bus.done <= 1'b1;
                  bus.sum  <= wk_n;
                  bus.cout <= s[SLICE];
`ifdef RCA_SEQ_OVERFLOW_EN
                  bus.ovf  <= msb_cin ^ s[SLICE];
`endif
               end
            end
            default: begin
               bus.done <= 1'b0;
               if (bus.start) begin
                  state    <= RUN;
                  bus.busy <= 1'b1;
                  a        <= bus.a;
                  b        <= bus.b;
                  c        <= bus.cin;
                  idx      <= '0;
               end else begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_rca_slice_sequencer.sv
// tb_rca_slice_sequencer: directed vectors plus a job-level model of the sequenced adder checked every cycle.
module tb_rca_slice_sequencer;
   localparam int WIDTH = 16;
   localparam int SLICE = 4;
   localparam int NSLICE = WIDTH / SLICE;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   rca_slice_sequencer_if #(.WIDTH(WIDTH)) bus ();
   rca_slice_sequencer #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (.clk(clk), .rst(rst), .bus(bus));
   int checks = 0;
   int errors = 0;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask
   // model: a job is accepted when none is pending, its result appears NSLICE edges later
   int             rem = 0;
   logic           m_done = 1'b0;
   logic [WIDTH:0] job = '0;
   logic [WIDTH:0] m_res = '0;
   logic           job_ovf = 1'b0;
   logic           m_ovf = 1'b0;
   initial forever begin
      @(posedge clk);
      #1;
      if (rst) begin
         rem = 0;
         m_done = 1'b0;
         m_res = '0;
         m_ovf = 1'b0;
      end else if (rem > 0) begin
         rem--;
         m_done = rem == 0;
         if (rem == 0) begin
            m_res = job;
            m_ovf = job_ovf;
         end
      end else begin
         m_done = 1'b0;
         if (bus.start) begin
            job = {1'b0, bus.a} + {1'b0, bus.b} + (WIDTH+1)'(bus.cin);
            job_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (job[WIDTH-1] != bus.a[WIDTH-1]);
            rem = NSLICE;
         end
      end
      chk("busy", 32'(bus.busy), 32'(rem > 0));
      chk("done", 32'(bus.done), 32'(m_done));
      chk("sum", 32'(bus.sum), 32'(m_res[WIDTH-1:0]));
      chk("cout", 32'(bus.cout), 32'(m_res[WIDTH]));
`ifdef RCA_SEQ_OVERFLOW_EN
      chk("ovf", 32'(bus.ovf), 32'(m_ovf));
`endif
   end
   task automatic run_add(input string name, input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic [15:0] exp_sum, input logic exp_cout, input logic exp_ovf);
      int n;
      bus.a = a;
      bus.b = b;
      bus.cin = cin;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      n = 1;
      while (!bus.done && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_latency"}, 32'(n), 32'(NSLICE + 1));
      chk({name, "_sum"}, 32'(bus.sum), 32'(exp_sum));
      chk({name, "_cout"}, 32'(bus.cout), 32'(exp_cout));
`ifdef RCA_SEQ_OVERFLOW_EN
      chk({name, "_ovf"}, 32'(bus.ovf), 32'(exp_ovf));
`else
      if (exp_ovf === 1'bx) $display("unexpected x flag");
`endif
   endtask
   initial begin
      int d[$];
      bus.start = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.cin = 1'b0;
      @(negedge clk);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_sum", 32'(bus.sum), 32'd0);
      chk("rst_cout", 32'(bus.cout), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      run_add("t1", 16'hA51B, 16'h52BB, 1'b0, 16'hF7D6, 1'b0, 1'b0);
      run_add("t2", 16'h372D, 16'hF359, 1'b0, 16'h2A86, 1'b1, 1'b0);
      run_add("t3a", 16'h5555, 16'hAAAA, 1'b1, 16'h0000, 1'b1, 1'b0);
      run_add("t3b", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
      // start held high with operands changing while the adder runs
      @(negedge clk);
      bus.a = 16'h1234;
      bus.b = 16'h0FFF;
      bus.cin = 1'b0;
      bus.start = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         if (bus.done) d.push_back(i);
         if (i == 5) chk("t4_first_sum", 32'(bus.sum), 32'h2233);
         bus.a = bus.a + 16'h0101;
         bus.b = bus.b ^ 16'h00F0;
      end
      bus.start = 1'b0;
      chk("t4_done_count", 32'(d.size()), 32'd3);
      if (d.size() == 3) begin
         chk("t4_first_done", 32'(d[0]), 32'd5);
         chk("t4_gap1", 32'(d[1] - d[0]), 32'd5);
         chk("t4_gap2", 32'(d[2] - d[1]), 32'd5);
      end
      repeat (8) @(negedge clk);
      // reset during the second RUN cycle
      bus.a = 16'h1111;
      bus.b = 16'h2222;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("t5_busy", 32'(bus.busy), 32'd0);
      chk("t5_done", 32'(bus.done), 32'd0);
      chk("t5_sum", 32'(bus.sum), 32'd0);
      chk("t5_cout", 32'(bus.cout), 32'd0);
      rst = 1'b0;
      repeat (6) @(negedge clk);
`ifdef RCA_SEQ_OVERFLOW_EN
      run_add("t6a", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      run_add("t6b", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
`endif
      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
